// File: rtl/vend_arbiter.sv
// ============================================================================
// Module      : vend_arbiter
// Description : Round-robin two-panel arbiter that screens purchases against a
//               price table and sequences accepted ones through vending_machine.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module vend_arbiter #(
  parameter int PRICE_DRINK = 3,
  parameter int PRICE_CHIP  = 2,
  parameter int SETTLE      = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic [2:0] sel0,
  input  logic [2:0] sel1,
  input  logic [2:0] amt0,
  input  logic [2:0] amt1,
  output logic [1:0] done,
  output logic       err,
  output logic [2:0] chg,
  output logic       busy,
  output logic [2:0] vm_select,
  output logic [2:0] vm_amnt,
  output logic       vm_b0,
  output logic       vm_b1,
  input  logic [2:0] vm_change
);

  localparam int             CW          = $clog2(SETTLE + 1);
  localparam logic [CW-1:0]  c_last      = CW'(SETTLE - 1);
  localparam logic [CW-1:0]  c_one       = CW'(1);
  localparam logic [2:0]     c_price_drk = 3'(PRICE_DRINK);
  localparam logic [2:0]     c_price_chp = 3'(PRICE_CHIP);

  typedef enum logic [3:0] {
    S_IDLE      = 4'd0,
    S_CHECK     = 4'd1,
    S_SEL_SETUP = 4'd2,
    S_SEL_PULSE = 4'd3,
    S_AMT_SETUP = 4'd4,
    S_AMT_PULSE = 4'd5,
    S_CHG_SETUP = 4'd6,
    S_CHG_PULSE = 4'd7,
    S_CHG_WAIT  = 4'd8,
    S_DONE      = 4'd9,
    S_REJECT    = 4'd10
  } state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_sel, r_amt, r_chg;
  logic          r_gnt, r_last;

  logic          w_gnt, w_cnt_last, w_sel_ok, w_reject;
  logic [2:0]    w_price;

  // r_last is the panel served most recently; on contention the other one wins
  assign w_gnt      = req[1] & (~req[0] | ~r_last);
  assign w_cnt_last = (r_cnt == c_last);

  always_comb begin
    w_price  = 3'd0;
    w_sel_ok = 1'b0;
    case (r_sel)
      3'b001:  begin w_price = c_price_drk; w_sel_ok = 1'b1; end
      3'b010:  begin w_price = c_price_chp; w_sel_ok = 1'b1; end
      default: begin w_price = 3'd0;        w_sel_ok = 1'b0; end
    endcase
    w_reject = ~w_sel_ok | (r_amt < w_price);
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    case (r_state)
      S_IDLE:      if (|req) w_state_nxt = S_CHECK;
      S_CHECK:     w_state_nxt = w_reject ? S_REJECT : S_SEL_SETUP;
      S_SEL_SETUP: if (w_cnt_last) w_state_nxt = S_SEL_PULSE; else w_cnt_nxt = r_cnt + c_one;
      S_SEL_PULSE: w_state_nxt = S_AMT_SETUP;
      S_AMT_SETUP: if (w_cnt_last) w_state_nxt = S_AMT_PULSE; else w_cnt_nxt = r_cnt + c_one;
      S_AMT_PULSE: w_state_nxt = S_CHG_SETUP;
      S_CHG_SETUP: if (w_cnt_last) w_state_nxt = S_CHG_PULSE; else w_cnt_nxt = r_cnt + c_one;
      S_CHG_PULSE: w_state_nxt = S_CHG_WAIT;
      S_CHG_WAIT:  if (w_cnt_last) w_state_nxt = S_DONE; else w_cnt_nxt = r_cnt + c_one;
      S_DONE:      w_state_nxt = S_IDLE;
      S_REJECT:    w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    done      = 2'b00;
    err       = 1'b0;
    busy      = (r_state != S_IDLE);
    vm_select = 3'd0;
    vm_amnt   = 3'd0;
    vm_b0     = 1'b1;
    vm_b1     = 1'b1;
    case (r_state)
      S_SEL_SETUP: vm_select = r_sel;
      S_SEL_PULSE: begin vm_select = r_sel; vm_b0 = 1'b0; end
      S_AMT_SETUP, S_CHG_SETUP, S_CHG_WAIT: vm_amnt = r_amt;
      S_AMT_PULSE, S_CHG_PULSE: begin vm_amnt = r_amt; vm_b0 = 1'b0; end
      S_DONE:      done[r_gnt] = 1'b1;
      S_REJECT:    begin done[r_gnt] = 1'b1; err = 1'b1; end
      default:     ;
    endcase
  end

  assign chg = r_chg;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel   <= 3'd0;
      r_amt   <= 3'd0;
      r_gnt   <= 1'b0;
      r_last  <= 1'b1;
      r_chg   <= 3'd0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (r_state == S_IDLE && |req) begin
        r_sel  <= w_gnt ? sel1 : sel0;
        r_amt  <= w_gnt ? amt1 : amt0;
        r_gnt  <= w_gnt;
        r_last <= w_gnt;
      end
      // chg must already read 0 in the REJECT cycle
      if (r_state == S_CHECK && w_reject)
        r_chg <= 3'd0;
      if (r_state == S_CHG_WAIT && w_cnt_last)
        r_chg <= vm_change;
    end
  end

endmodule

`default_nettype wire

// File: doc/vend_arbiter.md
# vend_arbiter

- Two-port arbiter and sequencer for the shared `vending_machine` core.
- Accepts purchase requests (item select plus inserted amount) from two front panels and grants one at a time, round-robin.
- Screens each request against a local price table. Accepted requests are driven through the core's select, insert and change steps with correctly spaced `b0` advance pulses; the returned change is captured.
- Sits between the panel logic and `vending_machine`, and is the only driver of the core's `select`, `amnt`, `b0` and `b1` inputs.

## Interface
Parameters:
- `PRICE_DRINK`, 3: price of item `3'b001`.
- `PRICE_CHIP`, 2: price of item `3'b010`.
- `SETTLE`, 2: setup/settle cycles around each `b0` pulse, ≥1.

Ports:
- Clocking: one clock, `clk`. Reset is synchronous and active-high, `rst`.
- `clk`  in  1  system clock.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  2  per-panel request, level; bit i = panel i.
- `sel0`, `sel1`  in  3  item code for each panel.
- `amt0`, `amt1`  in  3  amount inserted, unsigned, for each panel.
- `done`  out  2  one-cycle completion pulse, per panel.
- `err`  out  1  valid with `done`: 1 means the request was rejected.
- `chg`  out  3  change captured for the completed request; valid with `done` and held until the next `done`.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `vm_select`  out  3  drives the core's `select`.
- `vm_amnt`  out  3  drives the core's `amnt`.
- `vm_b0`  out  1  active-low advance strobe to the core.
- `vm_b1`  out  1  tied high in all states.
- `vm_change`  in  3  change output from the core.

## Operation
Reset values: `vm_select=0`, `vm_amnt=0`, `vm_b0=1`, `vm_b1=1`, `done=0`, `err=0`, `chg=0`, `busy=0`. The FSM resets to IDLE with the round-robin pointer favouring panel 0.

Arbitration (IDLE only):
- Only one panel requesting: that panel is granted.
- Both requesting: the panel not served last is granted.
- On grant, `selN` and `amtN` are latched. Later changes on the panel inputs have no effect on the in-flight transaction.
- The pointer updates on every grant, including rejected ones.

FSM states:
- **CHECK** (1 cycle):
  - Selects other than `001`/`010` go to REJECT.
  - An amount below the item's price (3-bit unsigned compare) goes to REJECT.
  - Otherwise go to SEL_SETUP.
- **SEL_SETUP** (`SETTLE` cycles): `vm_select` = latched select.
- **SEL_PULSE** (1 cycle): `vm_b0=0`, `vm_select` still driven.
- **AMT_SETUP** (`SETTLE` cycles): `vm_select=0`, `vm_amnt` = latched amount.
- **AMT_PULSE** (1 cycle): `vm_b0=0`.
- **CHG_SETUP** (`SETTLE` cycles).
- **CHG_PULSE** (1 cycle): `vm_b0=0`.
- **CHG_WAIT** (`SETTLE` cycles).
  - On the last CHG_WAIT edge, `chg <= vm_change`.
- **DONE** (1 cycle): `done[g]=1`, `err=0`, `vm_amnt` returns to 0. Next state IDLE.
- **REJECT** (1 cycle): `done[g]=1`, `err=1`, `chg=0`. Next state IDLE. The core is never touched.

Other rules:
- `vm_amnt` is held from AMT_SETUP through CHG_WAIT.
- A single shared counter, width clog2(`SETTLE`+1), times the setup and wait states.
- `vm_b0` is low only in the three PULSE states. It is never low in two consecutive cycles.
- The granted panel must drop `req` on `done`. Its `req` is not sampled in the DONE/REJECT cycle, and IDLE arbitrates on the following cycle.

## Timing
- Edge 0 is the edge that samples `req` in IDLE.
- Accepted request: `done` is high in the cycle after edge 4·`SETTLE`+4, i.e. the cycle after edge 12 with `SETTLE`=2.
- Rejected request: `done` and `err` are high in the cycle after edge 1.
- Back-to-back: minimum one IDLE cycle between transactions.
- `rst` mid-transaction:
  - At the next edge all outputs take their reset values and `vm_b0` returns high.
  - The transaction is abandoned with no `done`.
  - The pointer resets to favour panel 0.
- `req` asserted while `busy`: held off until IDLE. No request is lost as long as the panel holds `req`.

## Test plan
- Reset, then panel 0 requests `sel0=001`, `amt0=101`, core returns `010`:
  - `vm_b0` pulses low at edges 3, 6 and 9.
  - `vm_select=001` only during edges 1–3.
  - `done=01`, `err=0`, `chg=010` in the cycle after edge 12.
- Panel 1 requests `sel1=010`, `amt1=001`: REJECT.
  - `done=10`, `err=1` in the cycle after edge 1.
  - `vm_b0` stays 1 and `vm_select` stays 0 throughout.
- Both panels request on the same edge after reset:
  - Panel 0 is served first, panel 1 next.
  - Repeated simultaneous requests alternate 0,1,0,1.
- `sel0=011` (unknown code) with `amt0=111`: rejected with `err=1`.
- `rst` asserted during AMT_SETUP:
  - Next cycle: `vm_amnt=0`, `vm_b0=1`, `busy=0`, no `done`.
  - A fresh request afterwards completes normally.
- `SETTLE=1`, with `amt0` changed mid-transaction: `done` in the cycle after edge 8, and `chg` reflects the originally latched amount.
